// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between a bus master and the ALU issue controller.
// The master issues operations and consumes result beats; the controller is the slave.
interface alu_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_hi;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_hi
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_hi
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for the combinational ALU: latches one request, holds it for the
// class settle time, captures the 64-bit result and returns it as one or two 32-bit beats.
module alu_issue_ctrl #(
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MULDIV = 2
) (
  input  logic               clock,
  input  logic               clear,
  alu_issue_ctrl_if.slave    bus,
  output logic        [31:0] alu_a,
  output logic        [31:0] alu_b,
  output logic        [4:0]  alu_opcode,
  input  logic        [63:0] alu_c,
  output logic        [31:0] z_lo,
  output logic        [31:0] z_hi,
  output logic               busy,
  output logic               err_illegal
);

  localparam int LAT_MAX = (LAT_SIMPLE > LAT_MULDIV) ? LAT_SIMPLE : LAT_MULDIV;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_NOR  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;

  typedef enum logic [1:0] {IDLE, EXEC, SEND_LO, SEND_HI} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             two_beat;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL, OP_XOR, OP_NOR, OP_DIV, OP_MUL, OP_NEG, OP_NOT, OP_NOP: is_legal = 1'b1;
      default:                                                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Ready is forced low while clear is held so nothing is accepted during reset.
  assign bus.req_ready = (state == IDLE) && clear;
  assign busy          = (state != IDLE);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      cnt           <= '0;
      two_beat      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      z_lo          <= '0;
      z_hi          <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_hi    <= 1'b0;
      err_illegal   <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (!is_legal(bus.req_opcode)) begin
              err_illegal <= 1'b1;
            end else if (bus.req_opcode != OP_NOP) begin
              alu_a      <= bus.req_a;
              alu_b      <= bus.req_b;
              alu_opcode <= bus.req_opcode;
              two_beat   <= is_muldiv(bus.req_opcode);
              cnt        <= is_muldiv(bus.req_opcode) ? CNT_W'(LAT_MULDIV - 1)
                                                      : CNT_W'(LAT_SIMPLE - 1);
              state      <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            z_lo          <= alu_c[31:0];
            z_hi          <= alu_c[63:32];
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= alu_c[31:0];
            bus.rsp_hi    <= 1'b0;
            state         <= SEND_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SEND_LO: begin
          if (bus.rsp_ready) begin
            if (two_beat) begin
              bus.rsp_data <= z_hi;
              bus.rsp_hi   <= 1'b1;
              state        <= SEND_HI;
            end else begin
              bus.rsp_valid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        SEND_HI: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_hi    <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a behavioural ALU drives alu_c, and a queue-based
// transaction model predicts handshakes, beat contents and timing every cycle.
module tb_alu_issue_ctrl;

  localparam int LS = 1;
  localparam int LM = 2;

  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, MUL = 5'b10000, DIV = 5'b01111;
  localparam logic [4:0] NOP = 5'b11010;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] alu_a, alu_b, z_lo, z_hi;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  logic        busy, err_illegal;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.LAT_SIMPLE(LS), .LAT_MULDIV(LM)) dut (
    .clock(clock), .clear(clear), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .z_lo(z_lo), .z_hi(z_hi), .busy(busy), .err_illegal(err_illegal)
  );

  always #5 clock = ~clock;

  int nerr = 0;
  int ncheck = 0;

  logic [4:0] legal_ops [16] = '{5'b00011, 5'b00100, 5'b10000, 5'b01111, 5'b01001, 5'b01011,
                                 5'b01010, 5'b00111, 5'b01000, 5'b00101, 5'b00110, 5'b01101,
                                 5'b01110, 5'b10001, 5'b10010, 5'b11010};

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [4:0] s;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    s  = b[4:0];
    case (op)
      5'b00011: return sa + sb;
      5'b00100: return sa - sb;
      5'b10000: return sa * sb;
      5'b01111: return (b == 32'h0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
      5'b01001: return {32'h0, a >> s};
      5'b01011: return {32'h0, a << s};
      5'b01010: return {32'h0, 32'($signed(a) >>> s)};
      5'b00111: return {32'h0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
      5'b01000: return {32'h0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
      5'b00101: return {32'h0, a & b};
      5'b00110: return {32'h0, a | b};
      5'b01101: return {32'h0, a ^ b};
      5'b01110: return {32'h0, ~(a | b)};
      5'b10001: return 64'(-sa);
      5'b10010: return {32'h0, ~a};
      default:  return 64'h0;
    endcase
  endfunction

  always_comb alu_c = alu_fn(alu_opcode, alu_a, alu_b);

  function automatic bit legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction model: outstanding beats {hi, data}, cycles until the result is visible.
  logic [32:0] m_q[$];
  int          m_wait;
  logic [63:0] m_res, m_z;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op;
  logic        m_err;

  task automatic model_reset();
    m_q.delete();
    m_wait = 0; m_res = '0; m_z = '0;
    m_a = '0; m_b = '0; m_op = '0; m_err = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (m_q.size() != 0) && (m_wait == 0);
    chk("req_ready", 64'(bus.req_ready), 64'((m_q.size() == 0) && clear));
    chk("busy", 64'(busy), 64'(m_q.size() != 0));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
    if (exp_v) begin
      chk("rsp_data", 64'(bus.rsp_data), 64'(m_q[0][31:0]));
      chk("rsp_hi", 64'(bus.rsp_hi), 64'(m_q[0][32]));
    end
    chk("err_illegal", 64'(err_illegal), 64'(m_err));
    chk("alu_a", 64'(alu_a), 64'(m_a));
    chk("alu_b", 64'(alu_b), 64'(m_b));
    chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
    chk("z", {z_hi, z_lo}, m_z);
  endtask

  task automatic model_step(input bit acc, input bit con, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (!clear) begin
      model_reset();
      return;
    end
    m_err = 1'b0;
    if (acc) begin
      if (!legal(op)) m_err = 1'b1;
      else if (op != NOP) begin
        m_a = a; m_b = b; m_op = op;
        m_res = alu_fn(op, a, b);
        m_q.push_back({1'b0, m_res[31:0]});
        if (op == MUL || op == DIV) m_q.push_back({1'b1, m_res[63:32]});
        m_wait = (op == MUL || op == DIV) ? LM : LS;
      end
    end else if (m_q.size() != 0) begin
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_z = m_res;
      end else if (con) begin
        void'(m_q.pop_front());
      end
    end
  endtask

  // Called just after a rising edge; drives inputs, checks at the falling edge, advances model.
  task automatic cycle(input logic v, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rr);
    bit acc, con;
    bus.req_valid = v; bus.req_opcode = op; bus.req_a = a; bus.req_b = b;
    bus.rsp_ready = rr;
    @(negedge clock);
    check_outputs();
    acc = v && (m_q.size() == 0) && clear;
    con = (m_q.size() != 0) && (m_wait == 0) && rr;
    @(posedge clock);
    #1;
    model_step(acc, con, op, a, b);
  endtask

  task automatic run_idle();
    for (int i = 0; i < 40 && m_q.size() != 0; i++) cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    if (m_q.size() != 0) chk("drain_timeout", 64'(1), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'(0));
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_data"}, {31'h0, bus.rsp_hi, bus.rsp_data}, 64'(0));
    chk({tag, "_alu"}, {alu_a, alu_b}, 64'(0));
    chk({tag, "_op"}, {58'h0, alu_opcode, err_illegal}, 64'(0));
    chk({tag, "_z"}, {z_hi, z_lo}, 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [4:0] op;
    int r;
    clear = 1'b0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    clear = 1'b1;

    // add 5+7, single beat
    cycle(1'b1, ADD, 32'd5, 32'd7, 1'b1);
    run_idle();
    chk("add_z_lo", 64'(z_lo), 64'd12);

    // mul producing a result only in the high word
    cycle(1'b1, MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
    run_idle();
    chk("mul_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);

    // div with backpressure on both beats
    cycle(1'b1, DIV, 32'd1000, 32'd7, 1'b0);
    repeat (LM + 5) cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    repeat (3) cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    chk("div_z", {z_hi, z_lo}, {32'd6, 32'd142});

    // illegal then nop
    cycle(1'b1, 5'b11111, 32'h1234, 32'h5678, 1'b1);
    cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
    cycle(1'b1, NOP, 32'h9999, 32'h8888, 1'b1);
    repeat (2) cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);

    // request held while busy is taken only once idle
    cycle(1'b1, SUB, 32'd1, 32'd2, 1'b1);
    repeat (4) cycle(1'b1, ADD, 32'hDEAD_BEEF, 32'd1, 1'b1);
    run_idle();
    chk("held_alu_a", 64'(alu_a), 64'hDEAD_BEEF);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 19);
      if (r < 16) op = legal_ops[r];
      else op = 5'($urandom);
      cycle(1'($urandom_range(0, 9) < 6), op, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
            1'($urandom_range(0, 9) < 6));
    end
    run_idle();

    // reset during EXEC of a mul aborts it
    cycle(1'b1, MUL, 32'h1111, 32'h2222, 1'b0);
    clear = 1'b0;
    #1;
    model_reset();
    check_all_zero("midop");
    repeat (2) cycle(1'b1, ADD, 32'd3, 32'd4, 1'b1);
    clear = 1'b1;
    repeat (6) cycle(1'b0, 5'h0, 32'h0, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

endmodule
